// File: rtl/ni_flit_injector_pkg.sv
// Shared definitions for the network-interface flit injector and its credit logic.
package vr_ni_pkg;

  localparam int FLIT_DATA_WIDTH_DEF = 32;
  localparam int TYPE_W              = 2;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2
  } ni_state_e;

endpackage

// File: rtl/ni_flit_injector_if.sv
// Local-source packet/payload handshakes plus the router-facing flit and credit signals.
interface ni_flit_injector_if
  import vr_ni_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = FLIT_DATA_WIDTH_DEF,
  parameter int MAX_CREDITS     = 4,
  parameter int DEST_BITS       = 3,
  parameter int LEN_BITS        = 4
);
  localparam int CNT_W = $clog2(MAX_CREDITS + 1);

  logic                       pkt_valid;
  logic                       pkt_ready;
  logic [DEST_BITS-1:0]       pkt_dest;
  logic [LEN_BITS-1:0]        pkt_len;
  logic                       pl_valid;
  logic                       pl_ready;
  logic [FLIT_DATA_WIDTH-3:0] pl_data;
  logic [FLIT_DATA_WIDTH-1:0] flit_out;
  logic                       flit_valid;
  logic                       credit_increment;
  logic [CNT_W-1:0]           credit_count;
  logic                       credit_err;

  modport master (
    output pkt_valid, pkt_dest, pkt_len, pl_valid, pl_data, credit_increment,
    input  pkt_ready, pl_ready, flit_out, flit_valid, credit_count, credit_err
  );

  modport slave (
    input  pkt_valid, pkt_dest, pkt_len, pl_valid, pl_data, credit_increment,
    output pkt_ready, pl_ready, flit_out, flit_valid, credit_count, credit_err
  );

endinterface

// File: rtl/ni_flit_injector_credit_counter.sv
// Saturating credit counter for one downstream buffer; also usable by router output ports.
module credit_counter #(
  parameter  int MAX_CREDITS = 4,
  localparam int CNT_W       = $clog2(MAX_CREDITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CREDITS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Next credit value; an increment at full count is a protocol overflow and stays flagged.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case ({dec, inc})
      2'b10: begin
        if (count_q != {CNT_W{1'b0}}) count_d = count_q - CNT_W'(1);
        else                          count_d = count_q;
      end
      2'b01: begin
        if (count_q != MAX_C) count_d = count_q + CNT_W'(1);
        else                  err_d   = 1'b1;
      end
      default: count_d = count_q;
    endcase
  end

  // Credit and error state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= MAX_C;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/ni_flit_injector.sv
// Turns a header request plus a payload word stream into head/body/tail flits,
// gated by downstream credits.
module ni_flit_injector
  import vr_ni_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = FLIT_DATA_WIDTH_DEF,
  parameter int MAX_CREDITS     = 4,
  parameter int DEST_BITS       = 3,
  parameter int LEN_BITS        = 4
) (
  input  logic              clk,
  input  logic              reset,
  ni_flit_injector_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_CREDITS + 1);
  localparam int PL_W  = FLIT_DATA_WIDTH - TYPE_W;
  localparam int PAD_W = PL_W - DEST_BITS - LEN_BITS;

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_HEAD    = ST_HEAD;
  localparam logic [1:0] S_PAYLOAD = ST_PAYLOAD;

  logic [1:0]                 state_q, state_d;
  logic [DEST_BITS-1:0]       dest_q, dest_d;
  logic [LEN_BITS-1:0]        len_q, len_d;
  logic [LEN_BITS-1:0]        rem_q, rem_d;
  logic [FLIT_DATA_WIDTH-1:0] flit_q, flit_d;
  logic                       fvalid_q, fvalid_d;

  logic                       credit_ok_s;
  logic                       send_s;
  logic                       pl_hs_s;
  logic [CNT_W-1:0]           credit_count_s;
  logic [FLIT_DATA_WIDTH-1:0] head_flit_s;

  assign credit_ok_s = (credit_count_s != {CNT_W{1'b0}});
  assign pl_hs_s     = (state_q == S_PAYLOAD) && credit_ok_s && bus.pl_valid;
  assign send_s      = ((state_q == S_HEAD) && credit_ok_s) || pl_hs_s;
  assign head_flit_s = {FLIT_HEAD, dest_q, len_q, {PAD_W{1'b0}}};

  // Packet sequencing: accept header, emit head when a credit exists, then one flit per payload handshake.
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    rem_d    = rem_q;
    flit_d   = flit_q;
    fvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.pkt_valid) begin
          dest_d = bus.pkt_dest;
          len_d  = bus.pkt_len;
          rem_d  = bus.pkt_len;
          // Zero-length headers are consumed without producing any traffic.
          if (bus.pkt_len != {LEN_BITS{1'b0}}) state_d = S_HEAD;
          else                                 state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HEAD: begin
        if (credit_ok_s) begin
          flit_d   = head_flit_s;
          fvalid_d = 1'b1;
          state_d  = S_PAYLOAD;
        end else begin
          state_d = S_HEAD;
        end
      end
      S_PAYLOAD: begin
        if (pl_hs_s) begin
          fvalid_d = 1'b1;
          rem_d    = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) begin
            flit_d  = {FLIT_TAIL, bus.pl_data};
            state_d = S_IDLE;
          end else begin
            flit_d  = {FLIT_BODY, bus.pl_data};
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and the registered flit output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      dest_q   <= {DEST_BITS{1'b0}};
      len_q    <= {LEN_BITS{1'b0}};
      rem_q    <= {LEN_BITS{1'b0}};
      flit_q   <= {FLIT_DATA_WIDTH{1'b0}};
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      flit_q   <= flit_d;
      fvalid_q <= fvalid_d;
    end
  end

  credit_counter #(
    .MAX_CREDITS (MAX_CREDITS)
  ) u_credit_counter (
    .clk   (clk),
    .reset (reset),
    .dec   (send_s),
    .inc   (bus.credit_increment),
    .count (credit_count_s),
    .err   (bus.credit_err)
  );

  assign bus.pkt_ready    = (state_q == S_IDLE);
  assign bus.pl_ready     = (state_q == S_PAYLOAD) && credit_ok_s;
  assign bus.flit_out     = flit_q;
  assign bus.flit_valid   = fvalid_q;
  assign bus.credit_count = credit_count_s;

endmodule
